e_rr_arb_1hot: RTL and testbench
================================

Name: e_rr_arb_1hot

Overview:
- Round-robin arbiter that generates one-hot grants: the producer side of one-hot vectors that the team's one-hot checker consumes.
- Takes a W-bit request vector and issues a registered, stable one-hot grant with a binary index.
- Each grant is held until the consumer acknowledges it; priority then rotates past the granted requester.
- Sits in front of shared resources (ports, banks, queue slots) where downstream logic asserts one-hot on the grant.

Parameters:
- W, 4, number of requesters; W >= 1.
- IDX_W, (W > 1) ? $clog2(W) : 1, width of the binary grant index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst_n  input  1  asynchronous active-low reset.
- i_req  input  W  request vector; bit i set = requester i wants the resource.
- i_ack  input  1  consumer accepts the current grant; only meaningful while o_gnt_vld=1.
- o_gnt  output  W  registered grant; exactly one bit set when o_gnt_vld=1, all zero otherwise.
- o_gnt_vld  output  1  grant valid; always equals |o_gnt.
- o_gnt_idx  output  IDX_W  binary index of the set bit of o_gnt; 0 when o_gnt_vld=0.

Behaviour:
- Reset (arst_n low, asynchronous):
  - o_gnt=0, o_gnt_vld=0, o_gnt_idx=0.
  - Priority pointer ptr=one-hot bit 0.
  - State IDLE.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- State IDLE:
  - If i_req != 0: select the first set bit of i_req at or above ptr, wrapping modulo W.
  - Load the selected bit into o_gnt at the next edge and go to GRANT.
  - Latency from request to grant is 1 cycle.
  - If i_req == 0: stay in IDLE.
- State GRANT (o_gnt_vld=1):
  - o_gnt and o_gnt_idx hold stable until i_ack is sampled high.
  - Changes to i_req, including the granted requester dropping its request, do not alter or revoke the grant.
- Ack cycle (GRANT and i_ack=1):
  - ptr <= o_gnt rotated left by 1; bit W-1 wraps to bit 0.
  - Arbitrate among (i_req & ~o_gnt) starting at the new ptr.
  - Non-zero: load the new grant at the same edge and stay in GRANT. This gives back-to-back grants with no bubble.
  - Zero: clear o_gnt and go to IDLE. A sole requester therefore sees one idle cycle between consecutive grants.
- i_ack while o_gnt_vld=0 is ignored; no state change.
- Fairness: with all W requesting and acks every cycle, each requester is granted exactly once per W grants.
- Outputs are driven only from flops: o_gnt, o_gnt_idx and state are registered; no combinational path from i_req or i_ack to any output.
- W=1:
  - Grant is bit 0 whenever i_req[0]=1 in IDLE; o_gnt_idx is always 0.
  - Per the ack rule, a held request re-grants after one IDLE cycle.
- Invariants, to be asserted in RTL under simulation:
  - o_gnt is one-hot or zero.
  - o_gnt_vld == |o_gnt.
  - o_gnt_idx is consistent with o_gnt.
  - o_gnt is stable while vld && !ack.

Test Plan:
- Reset/first grant: W=4; assert arst_n low while o_gnt=0100 -> o_gnt=0000 and vld=0 before the next edge. Release, drive i_req=1111 -> o_gnt=0001, idx=0 one cycle later.
- Rotation: i_req=1111 held, i_ack=1 every cycle -> o_gnt sequence 0001,0010,0100,1000,0001 with o_gnt_vld continuously 1 and idx 0,1,2,3,0.
- Hold under backpressure: i_req=0100, i_ack=0 for 5 cycles, then i_req=0000 -> o_gnt stays 0100, idx=2, vld=1 throughout. Ack -> vld=0 next cycle, state IDLE.
- Wrap and mask: grant 1000 with i_req=1001 at ack -> next o_gnt=0001, not 1000; ptr wraps to bit 0.
- Sole requester: i_req=0010 held, ack on every grant -> o_gnt pattern 0010,0000,0010,0000; stray i_ack while vld=0 has no effect.
- W=1 instance: i_req=1, ack every grant -> o_gnt alternates 1/0, o_gnt_idx always 0, one-hot invariant never fires.

Source files
------------

// File: rtl/e_rr_arb_1hot.sv
// Round-robin arbiter producing a registered one-hot grant with binary index.
// A grant is held until acknowledged, then priority rotates past the winner.
module e_rr_arb_1hot #(
  parameter  int W     = 4,
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [W-1:0]     i_req,
  input  logic             i_ack,
  output logic [W-1:0]     o_gnt,
  output logic             o_gnt_vld,
  output logic [IDX_W-1:0] o_gnt_idx
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     gnt_q, gnt_d;
  logic [W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     req_masked;
  logic [W-1:0]     ptr_next;

  // First set bit of req at or above the one-hot ptr position, wrapping modulo W.
  function automatic logic [W-1:0] rr_pick(input logic [W-1:0] req, input logic [W-1:0] ptr);
    logic [W-1:0] res;
    int           base;
    int           j;
    logic         found;
    res   = '0;
    base  = 0;
    j     = 0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (ptr[i]) base = i;
    end
    for (int k = 0; k < W; k++) begin
      j = base + k;
      if (j >= W) j = j - W;
      if (!found && req[j]) begin
        res[j] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [W-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[(i + 1) % W] = v[i];
    end
    return r;
  endfunction

  // The granted requester is excluded from the re-arbitration on the ack edge.
  assign req_masked = i_req & ~gnt_q;
  assign ptr_next   = rotl1(gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          gnt_d   = rr_pick(i_req, ptr_q);
          idx_d   = onehot_to_idx(gnt_d);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (i_ack) begin
          ptr_d = ptr_next;
          if (|req_masked) begin
            gnt_d = rr_pick(req_masked, ptr_next);
            idx_d = onehot_to_idx(gnt_d);
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= W'(1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_idx = idx_q;
  assign o_gnt_vld = (state_q == S_GRANT);

`ifndef SYNTHESIS
  a_onehot0 : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(o_gnt));
  a_vld     : assert property (@(posedge clk) disable iff (!arst_n) o_gnt_vld == (|o_gnt));
  a_idx     : assert property (@(posedge clk) disable iff (!arst_n)
                o_gnt_vld ? (o_gnt == (W'(1) << o_gnt_idx)) : (o_gnt_idx == '0));
  a_stable  : assert property (@(posedge clk) disable iff (!arst_n)
                (o_gnt_vld && !i_ack) |=> $stable(o_gnt) && $stable(o_gnt_idx));
`endif

endmodule

// File: tb/tb_e_rr_arb_1hot.sv
// Directed bench for e_rr_arb_1hot: a W=4 instance driven from a vector table
// plus hand sequences for async reset and a W=1 instance.
module tb_e_rr_arb_1hot;

  logic       clk;
  logic       arst_n;
  logic [3:0] req4;
  logic       ack4;
  logic [3:0] gnt4;
  logic       vld4;
  logic [1:0] idx4;
  logic [0:0] req1;
  logic       ack1;
  logic [0:0] gnt1;
  logic       vld1;
  logic [0:0] idx1;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  e_rr_arb_1hot #(.W(4)) dut4 (
    .clk      (clk),
    .arst_n   (arst_n),
    .i_req    (req4),
    .i_ack    (ack4),
    .o_gnt    (gnt4),
    .o_gnt_vld(vld4),
    .o_gnt_idx(idx4)
  );

  e_rr_arb_1hot #(.W(1)) dut1 (
    .clk      (clk),
    .arst_n   (arst_n),
    .i_req    (req1),
    .i_ack    (ack1),
    .o_gnt    (gnt1),
    .o_gnt_vld(vld1),
    .o_gnt_idx(idx1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] g, input logic v, input logic [1:0] ix);
    check_output({tag, " gnt"}, 32'(gnt4), 32'(g));
    check_output({tag, " vld"}, 32'(vld4), 32'(v));
    check_output({tag, " idx"}, 32'(idx4), 32'(ix));
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic a);
    req4 = r;
    ack4 = a;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // rotation, idle return, backpressure hold, wrap/mask, sole requester, ptr memory
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[10] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[11] = '{4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[12] = '{4'b1011, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[14] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[15] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[17] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[18] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[19] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[20] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[22] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[23] = '{4'b1011, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[24] = '{4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[25] = '{4'b1011, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[26] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    arst_n = 1'b0;
    apply_stimulus(4'b0000, 1'b0);
    req1 = 1'b0;
    ack1 = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
    check4("reset", 4'b0000, 1'b0, 2'd0);
    check_output("reset w1 gnt", 32'(gnt1), 32'd0);

    // grant 0100, then pull reset mid-cycle and expect an immediate drop
    apply_stimulus(4'b0100, 1'b0);
    tick();
    check4("pre_rst", 4'b0100, 1'b1, 2'd2);
    #2;
    arst_n = 1'b0;
    #1;
    check4("async_rst", 4'b0000, 1'b0, 2'd0);
    tick();
    arst_n = 1'b1;
    apply_stimulus(4'b0000, 1'b0);
    check4("rst_hold", 4'b0000, 1'b0, 2'd0);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].ack);
      tick();
      check4($sformatf("row%0d", i), vecs[i].gnt, vecs[i].vld, vecs[i].idx);
    end

    // W=1: held request with ack every cycle alternates grant / idle
    apply_stimulus(4'b0000, 1'b0);
    req1 = 1'b1;
    ack1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output($sformatf("w1_%0d gnt", i), 32'(gnt1), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_output($sformatf("w1_%0d vld", i), 32'(vld1), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_output($sformatf("w1_%0d idx", i), 32'(idx1), 32'd0);
    end
    req1 = 1'b0;
    ack1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
